// File: rtl/clock_set_controller.sv
// Time-set sequencer: decodes Mode/Inc buttons into RUN/SET states and issues counter adjust pulses.
// Optional Inc auto-repeat in SET_HOUR/SET_MIN is enabled by defining SETCTL_AUTOREPEAT_EN.
module clock_set_controller #(
  parameter int unsigned TIMEOUT_S  = 10,
  parameter int unsigned HOLD_TICKS = 2
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic       Tick_1Hz,
  input  logic       Tick_Fast,
  input  logic       Btn_Mode,
  input  logic       Btn_Inc,
  output logic       Run_EN,
  output logic       Inc_Hour,
  output logic       Inc_Min,
  output logic       Clr_Sec,
  output logic [1:0] Field_Sel,
  output logic       Blink
);

  typedef enum logic [1:0] {S_RUN, S_HOUR, S_MIN, S_SEC} state_t;

  if (TIMEOUT_S < 1 || TIMEOUT_S > 255) begin : gen_bad_timeout
    $error("TIMEOUT_S must be in 1..255");
  end
  if (HOLD_TICKS < 1 || HOLD_TICKS > 15) begin : gen_bad_hold
    $error("HOLD_TICKS must be in 1..15");
  end

  localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT_S);

  state_t     state_q, state_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       btn_mode_q, btn_inc_q, armed_q;
  logic       run_en_q, run_en_d;
  logic       inc_hour_q, inc_hour_d;
  logic       inc_min_q, inc_min_d;
  logic       clr_sec_q, clr_sec_d;
  logic [1:0] field_sel_q, field_sel_d;
  logic       blink_q, blink_d;
  logic       rise_mode, rise_inc, rep, bump;

`ifdef SETCTL_AUTOREPEAT_EN
  localparam logic [3:0] HOLD_MAX = 4'(HOLD_TICKS);
  logic [3:0] hold_q, hold_d;
  logic       adj_state;
`endif

  always_comb begin
    // armed_q masks the first cycle after reset so a button already held produces no edge
    rise_mode = armed_q & Btn_Mode & ~btn_mode_q;
    rise_inc  = armed_q & Btn_Inc & ~btn_inc_q;
    rep       = 1'b0;
`ifdef SETCTL_AUTOREPEAT_EN
    adj_state = (state_q == S_HOUR) || (state_q == S_MIN);
    rep       = ~rise_mode & adj_state & Btn_Inc & Tick_Fast & (hold_q >= HOLD_MAX);
`endif
    bump = ~rise_mode & (state_q != S_RUN) & (rise_inc | rep);

    state_d = state_q;
    tcnt_d  = tcnt_q;
    if (rise_mode) begin
      tcnt_d = '0;
      case (state_q)
        S_RUN:   state_d = S_HOUR;
        S_HOUR:  state_d = S_MIN;
        S_MIN:   state_d = S_SEC;
        default: state_d = S_RUN;
      endcase
    end else if (state_q != S_RUN) begin
      if (bump) begin
        tcnt_d = '0;
      end else if (Tick_1Hz) begin
        tcnt_d = tcnt_q + 8'd1;
      end
      if (tcnt_d >= TIMEOUT_MAX) begin
        state_d = S_RUN;
      end
    end
    if (state_d == S_RUN) begin
      tcnt_d = '0;
    end

    inc_hour_d = bump & (state_q == S_HOUR);
    inc_min_d  = bump & (state_q == S_MIN);
    clr_sec_d  = bump & (state_q == S_SEC);
    run_en_d   = (state_d == S_RUN);

    case (state_d)
      S_HOUR:  field_sel_d = 2'b11;
      S_MIN:   field_sel_d = 2'b10;
      S_SEC:   field_sel_d = 2'b01;
      default: field_sel_d = 2'b00;
    endcase

    // Blank phase restarts on any change so the new value is visible immediately
    if (state_d == S_RUN || state_d != state_q || bump) begin
      blink_d = 1'b0;
    end else if (Tick_Fast) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end

`ifdef SETCTL_AUTOREPEAT_EN
    hold_d = '0;
    if (Btn_Inc && state_d == state_q) begin
      hold_d = hold_q;
      if (adj_state && Tick_Fast && hold_q < HOLD_MAX) begin
        hold_d = hold_q + 4'd1;
      end
    end
`endif
  end

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state_q     <= S_RUN;
      tcnt_q      <= '0;
      btn_mode_q  <= 1'b0;
      btn_inc_q   <= 1'b0;
      armed_q     <= 1'b0;
      run_en_q    <= 1'b1;
      inc_hour_q  <= 1'b0;
      inc_min_q   <= 1'b0;
      clr_sec_q   <= 1'b0;
      field_sel_q <= 2'b00;
      blink_q     <= 1'b0;
`ifdef SETCTL_AUTOREPEAT_EN
      hold_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      btn_mode_q  <= Btn_Mode;
      btn_inc_q   <= Btn_Inc;
      armed_q     <= 1'b1;
      run_en_q    <= run_en_d;
      inc_hour_q  <= inc_hour_d;
      inc_min_q   <= inc_min_d;
      clr_sec_q   <= clr_sec_d;
      field_sel_q <= field_sel_d;
      blink_q     <= blink_d;
`ifdef SETCTL_AUTOREPEAT_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign Run_EN    = run_en_q;
  assign Inc_Hour  = inc_hour_q;
  assign Inc_Min   = inc_min_q;
  assign Clr_Sec   = clr_sec_q;
  assign Field_Sel = field_sel_q;
  assign Blink     = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller: scripted scenarios plus randomized traffic
// compared against a mode-index reference model.
module tb_clock_set_controller;
  localparam int TO = 10;
  localparam int HT = 2;

  logic       Clk = 1'b0;
  logic       RST = 1'b0;
  logic       Tick_1Hz = 1'b0, Tick_Fast = 1'b0, Btn_Mode = 1'b0, Btn_Inc = 1'b0;
  logic       Run_EN, Inc_Hour, Inc_Min, Clr_Sec, Blink;
  logic [1:0] Field_Sel;

  clock_set_controller #(.TIMEOUT_S(TO), .HOLD_TICKS(HT)) dut (
    .Clk(Clk), .RST(RST), .Tick_1Hz(Tick_1Hz), .Tick_Fast(Tick_Fast),
    .Btn_Mode(Btn_Mode), .Btn_Inc(Btn_Inc), .Run_EN(Run_EN), .Inc_Hour(Inc_Hour),
    .Inc_Min(Inc_Min), .Clr_Sec(Clr_Sec), .Field_Sel(Field_Sel), .Blink(Blink)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode index 0=RUN,1=HOUR,2=MIN,3=SEC advanced modulo 4
  int m_idx, m_tcnt, m_hold;
  bit m_blink, m_armed, m_pm, m_pi, m_ph, m_pmn, m_pc;
  int cnt_h, cnt_m, cnt_c;

  function automatic logic [1:0] exp_field();
    return 2'((4 - m_idx) % 4);
  endfunction

  task automatic model_reset();
    m_idx = 0; m_tcnt = 0; m_hold = 0; m_blink = 0; m_armed = 0;
    m_pm = 0; m_pi = 0; m_ph = 0; m_pmn = 0; m_pc = 0;
  endtask

  task automatic model_step(input bit mode, input bit inc, input bit t1, input bit tf);
    int old;
    bit rm, ri, rep, bump;
    old = m_idx;
    rm  = m_armed && mode && !m_pm;
    ri  = m_armed && inc && !m_pi;
    rep = 0;
`ifdef SETCTL_AUTOREPEAT_EN
    rep = !rm && (old == 1 || old == 2) && inc && tf && (m_hold >= HT);
`endif
    bump  = !rm && old != 0 && (ri || rep);
    m_ph  = bump && old == 1;
    m_pmn = bump && old == 2;
    m_pc  = bump && old == 3;
    if (rm) begin
      m_idx = (old + 1) % 4;
      m_tcnt = 0;
    end else if (old != 0) begin
      if (bump) m_tcnt = 0;
      else if (t1) m_tcnt++;
      if (m_tcnt >= TO) m_idx = 0;
    end
    if (m_idx == 0) m_tcnt = 0;
    if (m_idx != old || !inc) m_hold = 0;
    else if (tf && (old == 1 || old == 2) && m_hold < HT) m_hold++;
    if (m_idx == 0 || m_idx != old || bump) m_blink = 0;
    else if (tf) m_blink = !m_blink;
    m_pm = mode; m_pi = inc; m_armed = 1;
  endtask

  task automatic cyc(input bit mode, input bit inc, input bit t1, input bit tf);
    Btn_Mode = mode; Btn_Inc = inc; Tick_1Hz = t1; Tick_Fast = tf;
    @(posedge Clk);
    if (RST) model_reset();
    else model_step(mode, inc, t1, tf);
    #1;
    Tick_1Hz = 0; Tick_Fast = 0;
    if (Inc_Hour) cnt_h++;
    if (Inc_Min) cnt_m++;
    if (Clr_Sec) cnt_c++;
  endtask

  task automatic press_mode();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic clear_counts();
    cnt_h = 0; cnt_m = 0; cnt_c = 0;
  endtask

  task automatic test_reset();
    #2 RST = 1;
    model_reset();
    #1;
    n_cmp++;
    if ({Run_EN, Inc_Hour, Inc_Min, Clr_Sec, Field_Sel, Blink} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_async outputs=%b required=1000000",
               {Run_EN, Inc_Hour, Inc_Min, Clr_Sec, Field_Sel, Blink});
    end
    // Hold reset 3 cycles with Mode pressed; release with Mode still held
    repeat (3) cyc(1, 0, 0, 0);
    RST = 0;
    repeat (3) cyc(1, 0, 0, 0);
    n_cmp++;
    if (Field_Sel !== 2'b00 || Run_EN !== 1'b1) begin
      n_bad++;
      $display("FAIL held_at_release field=%b run=%b required field=00 run=1", Field_Sel, Run_EN);
    end
    cyc(0, 0, 0, 0);
    clear_counts();
    repeat (3) begin
      cyc(0, 1, 0, 1);
      cyc(0, 0, 0, 0);
    end
    n_cmp++;
    if (cnt_h + cnt_m + cnt_c != 0 || Run_EN !== 1'b1 || Blink !== 1'b0) begin
      n_bad++;
      $display("FAIL inc_in_run pulses=%0d run=%b blink=%b required pulses=0 run=1 blink=0",
               cnt_h + cnt_m + cnt_c, Run_EN, Blink);
    end
    $display("test_reset done");
  endtask

  task automatic test_set_hour();
    press_mode();
    n_cmp++;
    if (Field_Sel !== 2'b11 || Run_EN !== 1'b0 || Blink !== 1'b0) begin
      n_bad++;
      $display("FAIL enter_hour field=%b run=%b blink=%b required 11/0/0", Field_Sel, Run_EN, Blink);
    end
    cyc(0, 0, 0, 1);
    n_cmp++;
    if (Blink !== 1'b1) begin
      n_bad++;
      $display("FAIL blink_toggle blink=%b required=1", Blink);
    end
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0);
      n_cmp++;
      if (Inc_Hour !== 1'b1 || Blink !== 1'b0) begin
        n_bad++;
        $display("FAIL hour_pulse_latency press=%0d inc_hour=%b blink=%b required 1/0", k, Inc_Hour, Blink);
      end
      cyc(0, 1, 0, 0);
      n_cmp++;
      if (Inc_Hour !== 1'b0) begin
        n_bad++;
        $display("FAIL hour_pulse_width press=%0d inc_hour=%b required=0", k, Inc_Hour);
      end
      cyc(0, 0, 0, 0);
    end
    n_cmp++;
    if (cnt_h != 3 || cnt_m != 0 || cnt_c != 0) begin
      n_bad++;
      $display("FAIL hour_pulse_count hour=%0d min=%0d sec=%0d required 3/0/0", cnt_h, cnt_m, cnt_c);
    end
    repeat (3) press_mode();
    $display("test_set_hour done");
  endtask

  task automatic test_set_sec();
    repeat (3) press_mode();
    n_cmp++;
    if (Field_Sel !== 2'b01 || Run_EN !== 1'b0) begin
      n_bad++;
      $display("FAIL enter_sec field=%b run=%b required 01/0", Field_Sel, Run_EN);
    end
    clear_counts();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    n_cmp++;
    if (cnt_c != 1 || cnt_h != 0 || cnt_m != 0) begin
      n_bad++;
      $display("FAIL sec_clear_count sec=%0d hour=%0d min=%0d required 1/0/0", cnt_c, cnt_h, cnt_m);
    end
    press_mode();
    n_cmp++;
    if (Field_Sel !== 2'b00 || Run_EN !== 1'b1) begin
      n_bad++;
      $display("FAIL sec_to_run field=%b run=%b required 00/1", Field_Sel, Run_EN);
    end
    $display("test_set_sec done");
  endtask

  task automatic test_simultaneous();
    repeat (2) press_mode();
    clear_counts();
    cyc(1, 1, 0, 0);
    n_cmp++;
    if (Field_Sel !== 2'b01 || Inc_Min !== 1'b0) begin
      n_bad++;
      $display("FAIL mode_beats_inc field=%b inc_min=%b required 01/0", Field_Sel, Inc_Min);
    end
    cyc(0, 0, 0, 0);
    n_cmp++;
    if (cnt_m + cnt_c + cnt_h != 0) begin
      n_bad++;
      $display("FAIL mode_beats_inc_count pulses=%0d required=0", cnt_m + cnt_c + cnt_h);
    end
    press_mode();
    $display("test_simultaneous done");
  endtask

  task automatic test_timeout();
    repeat (2) press_mode();
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 0, 1, 0);
      n_cmp++;
      if (Run_EN !== (k == 10)) begin
        n_bad++;
        $display("FAIL timeout_plain tick=%0d run=%b required=%0d", k, Run_EN, k == 10);
      end
      cyc(0, 0, 0, 0);
    end
    n_cmp++;
    if (Field_Sel !== 2'b00) begin
      n_bad++;
      $display("FAIL timeout_field field=%b required=00", Field_Sel);
    end
    repeat (2) press_mode();
    repeat (8) begin
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 1, 1, 0);
    n_cmp++;
    if (Inc_Min !== 1'b1 || Run_EN !== 1'b0) begin
      n_bad++;
      $display("FAIL tick9_with_inc inc_min=%b run=%b required 1/0", Inc_Min, Run_EN);
    end
    cyc(0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 0, 1, 0);
      n_cmp++;
      if (Run_EN !== (k == 10)) begin
        n_bad++;
        $display("FAIL timeout_restart tick=%0d run=%b required=%0d", k, Run_EN, k == 10);
      end
      cyc(0, 0, 0, 0);
    end
    $display("test_timeout done");
  endtask

  task automatic test_autorepeat();
    int want;
`ifdef SETCTL_AUTOREPEAT_EN
    want = 5;
`else
    want = 1;
`endif
    repeat (2) press_mode();
    clear_counts();
    cyc(0, 1, 0, 0);
    repeat (6) begin
      cyc(0, 1, 0, 1);
      cyc(0, 1, 0, 0);
    end
    cyc(0, 0, 0, 0);
    n_cmp++;
    if (cnt_m != want || cnt_h != 0) begin
      n_bad++;
      $display("FAIL autorepeat_count min=%0d hour=%0d required %0d/0", cnt_m, cnt_h, want);
    end
    repeat (2) press_mode();
    $display("test_autorepeat done");
  endtask

  task automatic test_rst_mid_set();
    press_mode();
    cyc(0, 1, 0, 0);
    n_cmp++;
    if (Inc_Hour !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_pulse inc_hour=%b required=1", Inc_Hour);
    end
    #2 RST = 1;
    model_reset();
    #1;
    n_cmp++;
    if (Inc_Hour !== 1'b0 || Run_EN !== 1'b1 || Field_Sel !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_set_reset inc_hour=%b run=%b field=%b required 0/1/00", Inc_Hour, Run_EN, Field_Sel);
    end
    repeat (2) cyc(0, 0, 0, 0);
    RST = 0;
    cyc(0, 0, 0, 0);
    $display("test_rst_mid_set done");
  endtask

  task automatic test_random();
    bit mode, inc, t1, tf;
    mode = 0; inc = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) mode = !mode;
      if ($urandom_range(0, 4) == 0) inc = !inc;
      t1 = ($urandom_range(0, 9) == 0);
      tf = ($urandom_range(0, 3) == 0);
      cyc(mode, inc, t1, tf);
      n_cmp++;
      if (Run_EN !== (m_idx == 0)) begin
        n_bad++;
        $display("FAIL rnd_run cyc=%0d got=%b required=%0d", n, Run_EN, m_idx == 0);
      end
      n_cmp++;
      if (Field_Sel !== exp_field()) begin
        n_bad++;
        $display("FAIL rnd_field cyc=%0d got=%b required=%b", n, Field_Sel, exp_field());
      end
      n_cmp++;
      if (Blink !== m_blink) begin
        n_bad++;
        $display("FAIL rnd_blink cyc=%0d got=%b required=%b", n, Blink, m_blink);
      end
      n_cmp++;
      if ({Inc_Hour, Inc_Min, Clr_Sec} !== {m_ph, m_pmn, m_pc}) begin
        n_bad++;
        $display("FAIL rnd_pulses cyc=%0d got=%b required=%b", n,
                 {Inc_Hour, Inc_Min, Clr_Sec}, {m_ph, m_pmn, m_pc});
      end
    end
    $display("test_random done");
  endtask

  initial begin
    model_reset();
    clear_counts();
    test_reset();
    test_set_hour();
    test_set_sec();
    test_simultaneous();
    test_timeout();
    test_autorepeat();
    test_rst_mid_set();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
